// File: rtl/multi_port_fifo_pkg.sv
// Shared types and lane-counting helpers for the multi-port FIFO.
// Lane vectors are sized for the widest supported configuration (4 lanes).
package multi_port_fifo_pkg;

    localparam int MAX_LANES  = 4;
    localparam int LANE_CNT_W = 3;

    typedef logic [MAX_LANES-1:0]  lane_vec_t;
    typedef logic [LANE_CNT_W-1:0] lane_cnt_t;

    function automatic lane_cnt_t popcount(input lane_vec_t v);
        lane_cnt_t n;
        n = 3'd0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + lane_cnt_t'(v[i]);
        end
        return n;
    endfunction

    // Counts the unbroken run of ones starting at lane 0.
    function automatic lane_cnt_t leading_ones(input lane_vec_t v);
        lane_cnt_t n;
        logic      run;
        n   = 3'd0;
        run = 1'b1;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (run && v[i]) begin
                n = n + 3'd1;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/multi_port_fifo.sv
// Multi-lane enqueue/dequeue FIFO with first-word fall-through outputs.
// Enabled enqueue lanes are compacted into consecutive slots at the tail.
module multi_port_fifo
    import multi_port_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ENQ_PORTS  = 2,
    parameter int DEQ_PORTS  = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ENQ_PORTS-1:0]              enqueue_en,
    input  logic [ENQ_PORTS*DATA_WIDTH-1:0]   enqueue_data,
    output logic                              enqueue_ready,
    output logic [DEQ_PORTS-1:0]              dequeue_valid,
    output logic [DEQ_PORTS*DATA_WIDTH-1:0]   dequeue_data,
    input  logic [DEQ_PORTS-1:0]              dequeue_en,
    input  logic                              flush,
    output logic [$clog2(DEPTH):0]            count,
    output logic                              full,
    output logic                              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    lane_vec_t             enq_vec_s;
    lane_vec_t             deq_vec_s;
    lane_cnt_t             push_s;
    lane_cnt_t             pop_s;
    logic [PTR_W-1:0]      wr_idx_s [ENQ_PORTS];

    assign enqueue_ready = (count_q <= CNT_W'(DEPTH - ENQ_PORTS));
    assign count         = count_q;
    assign full          = (count_q == CNT_W'(DEPTH));
    assign empty         = (count_q == {CNT_W{1'b0}});

    always_comb begin
        dequeue_valid = '0;
        dequeue_data  = '0;
        for (int i = 0; i < DEQ_PORTS; i++) begin
            if (count_q > CNT_W'(i)) begin
                dequeue_valid[i] = 1'b1;
                dequeue_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[head_q + PTR_W'(i)];
            end else begin
                dequeue_valid[i] = 1'b0;
            end
        end
    end

    // Push/pop amounts, compacted write slots and next pointer state.
    always_comb begin
        enq_vec_s = '0;
        deq_vec_s = '0;
        if (enqueue_ready) begin
            enq_vec_s[ENQ_PORTS-1:0] = enqueue_en;
        end else begin
            enq_vec_s = '0;
        end
        deq_vec_s[DEQ_PORTS-1:0] = dequeue_en & dequeue_valid;
        push_s = popcount(enq_vec_s);
        pop_s  = leading_ones(deq_vec_s);
        for (int i = 0; i < ENQ_PORTS; i++) begin
            wr_idx_s[i] = tail_q + PTR_W'(popcount(enq_vec_s & ((lane_vec_t'(1) << i) - lane_vec_t'(1))));
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop_s);
            tail_d  = tail_q + PTR_W'(push_s);
            count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not cleared; only slots below count are ever observable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_PORTS; i++) begin
            if (enq_vec_s[i] && !flush && !reset) begin
                mem_q[wr_idx_s[i]] <= enqueue_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule
